// File: rtl/keypad_lock_ctrl.sv
// keypad_lock_ctrl
//   Keypad door-lock controller. It collects CODE_LEN digits from a one-hot
//   button bank and compares them against a runtime-writable code register.
//   The verdict is given only after the last digit. A correct code gives a
//   timed unlock with the green LED. A wrong code blinks the red LED and,
//   optionally, leads to a lockout after repeated failures.
//
//   Optional feature macro: LOCKOUT_EN
//     defined   -> fail counter, LOCKOUT state and locked_out are active
//     undefined -> ERROR always returns to IDLE; fail_cnt/locked_out tied 0
//
// Ports
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   btn        in   debounced buttons, bit i = digit i
//   code_we    in   load code_in into the code register (IDLE only)
//   code_in    in   new code, digit i at [i*BW +: BW]
//   unlock     out  door release
//   green_led  out  success indication
//   red_led    out  error / lockout indication
//   locked_out out  lockout active
//   fail_cnt   out  consecutive failure count
module keypad_lock_ctrl #(
   parameter int NUM_BTN     = 4,
   parameter int CODE_LEN    = 4,
   localparam int BW         = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1,
   parameter logic [CODE_LEN*BW-1:0] DEFAULT_CODE = 8'hD8,
   parameter int TIMEOUT_CYC = 10,
   parameter int GREEN_CYC   = 3,
   parameter int BLINK_CYC   = 1,
   parameter int RED_BLINKS  = 2,
   parameter int MAX_FAILS   = 3,
   parameter int LOCKOUT_CYC = 20,
   localparam int FW         = $clog2(MAX_FAILS + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_BTN-1:0]     btn,
   input  logic                   code_we,
   input  logic [CODE_LEN*BW-1:0] code_in,
   output logic                   unlock,
   output logic                   green_led,
   output logic                   red_led,
   output logic                   locked_out,
   output logic [FW-1:0]          fail_cnt
);

   localparam int IW      = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
   localparam int ERR_CYC = 2 * BLINK_CYC * RED_BLINKS;
   localparam int MAX_A   = (TIMEOUT_CYC > GREEN_CYC) ? TIMEOUT_CYC : GREEN_CYC;
   localparam int MAX_B   = (ERR_CYC > LOCKOUT_CYC) ? ERR_CYC : LOCKOUT_CYC;
   localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW      = $clog2(MAX_CYC + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ENTRY   = 3'd1;
   localparam logic [2:0] S_OPEN    = 3'd2;
   localparam logic [2:0] S_ERROR   = 3'd3;
   localparam logic [2:0] S_LOCKOUT = 3'd4;

   logic [2:0]             state;
   logic [CODE_LEN*BW-1:0] code_q;
   logic [NUM_BTN-1:0]     btn_q;
   logic [IW-1:0]          idx;
   logic                   mismatch;
   logic [CW-1:0]          cnt;   // shared: entry timer / open / error / lockout
   logic [CW-1:0]          ph;    // red blink half-period counter
   logic                   open_q;

   logic          press, one_hot, miss, last_digit, verdict, fail_v;
   logic [BW-1:0] digit, ref_digit;

   // Highest set bit; multi-hot presses are forced to mismatch via one_hot.
   always_comb begin
      digit = '0;
      for (int i = 0; i < NUM_BTN; i++)
         if (btn[i]) digit = BW'(i);
   end

   assign press      = (btn != '0) && (btn_q == '0);
   assign one_hot    = (btn & (btn - NUM_BTN'(1))) == '0;
   assign ref_digit  = code_q[idx*BW +: BW];
   assign miss       = !one_hot || (digit != ref_digit);
   assign last_digit = (idx == IW'(CODE_LEN - 1));

   // Verdict fires on the final digit; CODE_LEN==1 judges straight from IDLE.
   assign verdict = press && (((state == S_IDLE) && (CODE_LEN == 1)) ||
                              ((state == S_ENTRY) && last_digit));
   assign fail_v  = miss || ((state == S_ENTRY) && mismatch);

   assign unlock    = open_q;
   assign green_led = open_q;

`ifndef LOCKOUT_EN
   assign fail_cnt   = '0;
   assign locked_out = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         code_q   <= DEFAULT_CODE;
         btn_q    <= '0;
         idx      <= '0;
         mismatch <= 1'b0;
         cnt      <= '0;
         ph       <= '0;
         open_q   <= 1'b0;
         red_led  <= 1'b0;
`ifdef LOCKOUT_EN
         fail_cnt   <= '0;
         locked_out <= 1'b0;
`endif
      end else begin
         // History runs in every state so a button held across a return to
         // IDLE never counts as a fresh press.
         btn_q <= btn;
         case (state)
            S_IDLE: begin
               // Same-cycle press still reads the old code_q.
               if (code_we) code_q <= code_in;
               if (press) begin
                  mismatch <= miss;
                  idx      <= IW'(1);
                  cnt      <= '0;
                  state    <= S_ENTRY;
               end
            end
            S_ENTRY: begin
               // A press on the timeout edge wins over the timeout.
               if (press) begin
                  mismatch <= mismatch | miss;
                  idx      <= idx + IW'(1);
                  cnt      <= '0;
               end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                  state    <= S_IDLE;
                  idx      <= '0;
                  mismatch <= 1'b0;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_OPEN: begin
               if (cnt == CW'(GREEN_CYC - 1)) begin
                  state  <= S_IDLE;
                  open_q <= 1'b0;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_ERROR: begin
               if (cnt == CW'(ERR_CYC - 1)) begin
                  cnt <= '0;
                  ph  <= '0;
`ifdef LOCKOUT_EN
                  if (fail_cnt == FW'(MAX_FAILS)) begin
                     state      <= S_LOCKOUT;
                     locked_out <= 1'b1;
                     red_led    <= 1'b1;
                  end else begin
                     state   <= S_IDLE;
                     red_led <= 1'b0;
                  end
`else
                  state   <= S_IDLE;
                  red_led <= 1'b0;
`endif
               end else begin
                  cnt <= cnt + CW'(1);
                  if (ph == CW'(BLINK_CYC - 1)) begin
                     ph      <= '0;
                     red_led <= ~red_led;
                  end else begin
                     ph <= ph + CW'(1);
                  end
               end
            end
            S_LOCKOUT: begin
`ifdef LOCKOUT_EN
               if (cnt == CW'(LOCKOUT_CYC - 1)) begin
                  state      <= S_IDLE;
                  locked_out <= 1'b0;
                  red_led    <= 1'b0;
                  fail_cnt   <= '0;
                  cnt        <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
`else
               state <= S_IDLE;
`endif
            end
            default: state <= S_IDLE;
         endcase

         // Final digit overrides the per-state entry bookkeeping above.
         if (verdict) begin
            idx      <= '0;
            mismatch <= 1'b0;
            cnt      <= '0;
            ph       <= '0;
            if (fail_v) begin
               state   <= S_ERROR;
               red_led <= 1'b1;
`ifdef LOCKOUT_EN
               if (fail_cnt != FW'(MAX_FAILS)) fail_cnt <= fail_cnt + FW'(1);
`endif
            end else begin
               state  <= S_OPEN;
               open_q <= 1'b1;
`ifdef LOCKOUT_EN
               fail_cnt <= '0;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Testbench for keypad_lock_ctrl with default parameters. Expected output
// words are {unlock, green_led, red_led, locked_out, fail_cnt[1:0]}.
// locked_out/fail_cnt expectations are zeroed unless LOCKOUT_EN is defined.
module tb_keypad_lock_ctrl;

`ifdef LOCKOUT_EN
   localparam int LK = 1;
`else
   localparam int LK = 0;
`endif

   logic       clk, reset, code_we;
   logic [3:0] btn;
   logic [7:0] code_in;
   logic       unlock, green_led, red_led, locked_out;
   logic [1:0] fail_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [3:0] b;
      logic [5:0] e;
   } vec_t;
   vec_t vecs[$];

   keypad_lock_ctrl dut (
      .clk(clk), .reset(reset), .btn(btn), .code_we(code_we), .code_in(code_in),
      .unlock(unlock), .green_led(green_led), .red_led(red_led),
      .locked_out(locked_out), .fail_cnt(fail_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [5:0] e);
      logic [5:0] em, act;
      em      = e;
      em[2]   = (LK != 0) ? e[2] : 1'b0;
      em[1:0] = (LK != 0) ? e[1:0] : 2'b00;
      act     = {unlock, green_led, red_led, locked_out, fail_cnt};
      n_tests++;
      if (act !== em) begin
         n_fail++;
         $display("FAIL %s: u/g/r/l/fc got %b required %b", nm, act, em);
      end
   endtask

   task automatic key(input logic [3:0] b);
      btn = b;
      tick();
      btn = '0;
   endtask

   task automatic enter(input logic [3:0] b0, b1, b2, b3);
      key(b0); tick();
      key(b1); tick();
      key(b2); tick();
      key(b3);
   endtask

   task automatic open_wait(input string nm);
      chk({nm, "_open0"}, 6'b110000);
      tick(); tick();
      chk({nm, "_open2"}, 6'b110000);
      tick();
      chk({nm, "_closed"}, 6'b000000);
   endtask

   task automatic err_wait(input string nm, input logic [1:0] f, input logic [5:0] end_e);
      chk({nm, "_red0"}, {4'b0010, f}); tick();
      chk({nm, "_red1"}, {4'b0000, f}); tick();
      chk({nm, "_red2"}, {4'b0010, f}); tick();
      chk({nm, "_red3"}, {4'b0000, f}); tick();
      chk({nm, "_end"}, end_e);
   endtask

   task automatic add(input logic [3:0] b, input logic [5:0] e);
      vec_t v;
      v.b = b;
      v.e = e;
      vecs.push_back(v);
   endtask

   // First three digits with a gap after each; final digit added by caller.
   task automatic code6(input logic [3:0] b0, b1, b2, input logic [5:0] e);
      add(b0, e); add(4'b0000, e);
      add(b1, e); add(4'b0000, e);
      add(b2, e); add(4'b0000, e);
   endtask

   initial begin
      reset = 1'b1; btn = '0; code_we = 1'b0; code_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", 6'b000000);
      reset = 1'b0;

      // ---- table: correct code, wrong code, held button, multi-hot ----
      add(4'b0000, 6'b000000);
      code6(4'b0001, 4'b0100, 4'b0010, 6'b000000);
      add(4'b1000, 6'b110000); add(4'b0000, 6'b110000);
      add(4'b0000, 6'b110000); add(4'b0000, 6'b000000);
      code6(4'b0001, 4'b0010, 4'b0100, 6'b000000);
      add(4'b1000, 6'b001001); add(4'b0000, 6'b000001);
      add(4'b0000, 6'b001001); add(4'b0000, 6'b000001);
      add(4'b0000, 6'b000001);
      repeat (5) add(4'b0001, 6'b000001);
      add(4'b0000, 6'b000001); add(4'b0100, 6'b000001);
      add(4'b0000, 6'b000001); add(4'b0010, 6'b000001);
      add(4'b0000, 6'b000001);
      add(4'b1000, 6'b110000); add(4'b0000, 6'b110000);
      add(4'b0000, 6'b110000); add(4'b0000, 6'b000000);
      code6(4'b0001, 4'b0110, 4'b0010, 6'b000000);
      add(4'b1000, 6'b001001); add(4'b0000, 6'b000001);
      add(4'b0000, 6'b001001); add(4'b0000, 6'b000001);
      add(4'b0000, 6'b000001);

      foreach (vecs[i]) begin
         btn = vecs[i].b;
         tick();
         chk($sformatf("vec%0d", i), vecs[i].e);
      end
      btn = '0;

      // ---- timeout: 10 idle cycles after second digit aborts entry ----
      key(4'b0001); tick(); key(4'b0100);
      repeat (10) tick();
      chk("timeout_idle", 6'b000001);
      enter(4'b0001, 4'b0100, 4'b0010, 4'b1000);
      open_wait("after_timeout");

      // ---- press on the timeout edge wins ----
      key(4'b0001);
      repeat (9) tick();
      key(4'b0100); tick();
      key(4'b0010); tick();
      key(4'b1000);
      open_wait("timeout_edge");

      // ---- runtime code write ----
      code_we = 1'b1; code_in = 8'h1B; tick(); code_we = 1'b0;
      enter(4'b1000, 4'b0100, 4'b0010, 4'b0001);
      open_wait("new_code");
      enter(4'b0001, 4'b0100, 4'b0010, 4'b1000);
      err_wait("old_code", 2'd1, 6'b000001);
      key(4'b1000);
      code_we = 1'b1; code_in = 8'hD8; tick(); code_we = 1'b0;
      key(4'b0100); tick(); key(4'b0010); tick(); key(4'b0001);
      open_wait("we_in_entry");
      // press and write in the same IDLE cycle: old code for digit 0 only
      btn = 4'b1000; code_we = 1'b1; code_in = 8'hD8; tick();
      btn = '0; code_we = 1'b0; tick();
      key(4'b0100); tick(); key(4'b0010); tick(); key(4'b1000);
      open_wait("we_with_press");

      // ---- three consecutive failures ----
      enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
      err_wait("fail1", 2'd1, 6'b000001);
      enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
      err_wait("fail2", 2'd2, 6'b000010);
      enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
`ifdef LOCKOUT_EN
      err_wait("fail3", 2'd3, 6'b001111);
      enter(4'b0001, 4'b0100, 4'b0010, 4'b1000);
      chk("lockout_ignores_press", 6'b001111);
      repeat (12) tick();
      chk("lockout_last", 6'b001111);
      tick();
      chk("lockout_done", 6'b000000);
`else
      err_wait("fail3", 2'd3, 6'b000000);
`endif
      enter(4'b0001, 4'b0100, 4'b0010, 4'b1000);
      open_wait("after_fails");

      // ---- reset during OPEN ----
      enter(4'b0001, 4'b0100, 4'b0010, 4'b1000);
      chk("pre_reset_open", 6'b110000);
      reset = 1'b1; #2;
      chk("reset_in_open", 6'b000000);
      reset = 1'b0;
      tick();

      // ---- reset mid-ENTRY restores default code ----
      enter(4'b0001, 4'b0010, 4'b0100, 4'b1000);
      err_wait("pre_reset_err", 2'd1, 6'b000001);
      code_we = 1'b1; code_in = 8'h1B; tick(); code_we = 1'b0;
      key(4'b1000); tick(); key(4'b0100);
      reset = 1'b1; #2;
      chk("reset_in_entry", 6'b000000);
      reset = 1'b0;
      tick();
      enter(4'b0001, 4'b0100, 4'b0010, 4'b1000);
      open_wait("default_code_back");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_lock_ctrl.md
# keypad_lock_ctrl

Parametrised successor to the 4-button door-lock controller. It accepts a code of configurable length from a one-hot button bank and holds that code in a runtime-writable register. A code is judged only after all digits are entered. It drives a timed unlock/green indication, a blinking red error indication and an optional lockout after repeated failures, and sits between the debounced keypad inputs and the door actuator/LED drivers.

## Interface
- NUM_BTN, 4: number of keypad buttons; BW = max(1, $clog2(NUM_BTN)) bits per digit
- CODE_LEN, 4: digits per code
- DEFAULT_CODE, 8'hD8: reset value of code register (CODE_LEN*BW bits); digit i at [i*BW +: BW], digit 0 entered first (default = 0,2,1,3)
- TIMEOUT_CYC, 10: idle cycles in ENTRY before abort
- GREEN_CYC, 3: unlock/green hold cycles
- BLINK_CYC, 1: red on/off half-period in cycles
- RED_BLINKS, 2: red blink pulses per error
- MAX_FAILS, 3: consecutive failures triggering lockout
- LOCKOUT_CYC, 20: lockout duration in cycles
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- btn  in  NUM_BTN  debounced buttons, bit i = digit i
- code_we  in  1  load code_in into code register
- code_in  in  CODE_LEN*BW  new code
- unlock  out  1  door release
- green_led  out  1  success indication
- red_led  out  1  error/lockout indication
- locked_out  out  1  lockout active
- fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failure count

## Operation
- All outputs registered. Reset: state IDLE, code = DEFAULT_CODE, all counters 0, unlock/green_led/red_led/locked_out/fail_cnt = 0, btn history = 0.
- Press event: btn != 0 in a cycle where the previous-cycle btn == 0. A held button yields one press. One-hot btn gives digit = bit index. Multi-hot gives a press that always mismatches.
- IDLE: a press stores a mismatch flag (digit != code digit 0), sets idx = 1 and moves to ENTRY. If CODE_LEN == 1, it moves directly to the verdict instead.
- ENTRY: each press ORs (digit != code[idx]) into mismatch and increments idx. The press with idx == CODE_LEN-1 ends entry: state goes to OPEN if mismatch is clear, else to ERROR. No early rejection.
- ENTRY timeout: the timer clears on every press and increments otherwise. With no press for TIMEOUT_CYC consecutive cycles, state goes to IDLE, idx and mismatch clear, and fail_cnt is unchanged.
- OPEN: unlock = green_led = 1 for exactly GREEN_CYC cycles, then IDLE. fail_cnt clears on entry. Presses ignored.
- ERROR: fail_cnt increments (saturating at MAX_FAILS) on entry. red_led runs 1 for BLINK_CYC, 0 for BLINK_CYC, repeated RED_BLINKS times (2*BLINK_CYC*RED_BLINKS cycles). It then goes to LOCKOUT if fail_cnt == MAX_FAILS, else IDLE. Presses ignored.
- LOCKOUT: locked_out = red_led = 1 steady for LOCKOUT_CYC cycles, then IDLE with fail_cnt = 0. Presses and code_we ignored.
- code_we is honoured only in IDLE, where the register loads at that edge. In any other state code_we is ignored, with no deferred write.
- A press and code_we in the same IDLE cycle: the press is compared against the old code, and the new code applies from the next digit onward.
- Reset mid-operation aborts immediately to reset values, including the code register.

## Timing
- Final press sampled at edge k: state changes at edge k. unlock/green_led are high for cycles k+1 .. k+GREEN_CYC and low after edge k+GREEN_CYC.
- Error: red_led first goes high in cycle k+1. For the default parameters the pattern over cycles k+1..k+4 is 1,0,1,0. State is IDLE (or LOCKOUT) from edge k+4.
- Timeout: the last press at edge p returns the block to IDLE at edge p+TIMEOUT_CYC. A press sampled at that same edge wins: it counts as a press and restarts the timer.
- A button held across an OPEN/ERROR/LOCKOUT→IDLE transition does not produce a press. A new 0→1 edge is required.

## Configuration
- LOCKOUT_EN defined: fail counter, LOCKOUT state and locked_out behave as above.
- LOCKOUT_EN undefined: there is no LOCKOUT state and ERROR always returns to IDLE. fail_cnt and locked_out are tied to 0, and MAX_FAILS/LOCKOUT_CYC are unused.

## Test plan
- Defaults: press btn 0001,0100,0010,1000 with a 0000 gap between each → unlock/green_led high exactly 3 cycles after the last press edge; fail_cnt = 0.
- Press 0001,0010,0100,1000 → no unlock; red_led 1,0,1,0; fail_cnt = 1; IDLE after 4 cycles.
- Three wrong codes (LOCKOUT_EN) → third error blink, then locked_out = red_led = 1 for 20 cycles. Presses during lockout are ignored. Then fail_cnt = 0 and the correct code opens.
- Press 0001,0100, then idle 10 cycles → back in IDLE, no red, fail_cnt unchanged; the full correct code then opens.
- code_we with code_in = 8'h1B in IDLE → 3,2,1,0 opens and 0,2,1,3 errors. code_we asserted during ENTRY → ignored.
- Assert reset during OPEN and again mid-ENTRY → all outputs 0 immediately; code back to 8'hD8. Holding btn 0001 for 5 cycles counts as one press.
